bkram_wb_responder: RTL



---
 rtl/bus_pkg.sv | 24 ++
 rtl/bkram_wb_responder_if.sv | 38 +++
 rtl/bkram_bytewide.sv | 49 ++++
 rtl/bkram_wb_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
//   Shared CPU-bus definitions.
//   - BUS_AW / BUS_DW : word-address and data widths of the CPU bus.
//   - BKRAM_ADDR_DEF / BKRAM_MASK_DEF : block-RAM window. The data cache's
//     cachability decode uses these same constants, so the responder and the
//     cache always agree on which addresses belong to the block RAM.
//   - rsp_e : the kind of response a pipeline slot carries.
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int BUS_AW = 30;
  localparam int BUS_DW = 32;

  localparam logic [BUS_AW-1:0] BKRAM_ADDR_DEF = 30'h4000000;
  localparam logic [BUS_AW-1:0] BKRAM_MASK_DEF = 30'h4000000;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_e;

endpackage

// File: rtl/bkram_wb_responder_if.sv
// ---------------------------------------------------------------------------
// bkram_wb_responder_if
//   Pipelined Wishbone B4 bus bundle between the CPU bus master and the
//   block-RAM responder.
//   Master -> slave : i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr[AW], i_wb_data[DW],
//                     i_wb_sel[DW/8]
//   Slave -> master : o_wb_stall, o_wb_ack, o_wb_data[DW], o_wb_err
//   Signal names are given from the responder's point of view.
// ---------------------------------------------------------------------------
interface bkram_wb_responder_if
  import bus_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
);

  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_addr;
  logic [DW-1:0] i_wb_data;
  logic [DW/8-1:0] i_wb_sel;
  logic          o_wb_stall;
  logic          o_wb_ack;
  logic [DW-1:0] o_wb_data;
  logic          o_wb_err;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_data, o_wb_err
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_data, o_wb_err
  );

endinterface

// File: rtl/bkram_bytewide.sv
// ---------------------------------------------------------------------------
// bkram_bytewide
//   Synchronous single-port RAM, 2**LGMEMSZ words of DW bits, with per-byte
//   write enables and a registered read port.
//   Ports:
//     i_clk    : clock
//     i_we     : write strobe (bytes with i_sel[k]=1 are written)
//     i_re     : read strobe (o_rdata updates on the next edge)
//     i_addr   : word index
//     i_wdata  : write data
//     i_sel    : byte-lane selects
//     o_rdata  : registered read data
//   Contents and read register are not reset.
// ---------------------------------------------------------------------------
module bkram_bytewide #(
  parameter int LGMEMSZ = 12,
  parameter int DW      = 32
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [LGMEMSZ-1:0] i_addr,
  input  logic [DW-1:0]      i_wdata,
  input  logic [DW/8-1:0]    i_sel,
  output logic [DW-1:0]      o_rdata
);

  localparam int NBYTES = DW / 8;
  localparam int DEPTH  = 1 << LGMEMSZ;

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_sel[k]) begin
          mem_q[i_addr][k*8 +: 8] <= i_wdata[k*8 +: 8];
        end
      end
    end
    if (i_re) begin
      rdata_q <= mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/bkram_wb_responder.sv
// ---------------------------------------------------------------------------
// bkram_wb_responder
//   Pipelined Wishbone B4 responder for the on-chip block RAM (the cachable
//   region of the data cache). Accepts one request per clock, never stalls,
//   and answers each accepted request exactly two cycles later, in order.
//   Dropping i_wb_cyc aborts everything in flight: no response is produced
//   for aborted requests, but writes that already reached the RAM stay.
//
//   Ports:
//     i_clk      : clock
//     i_reset_n  : asynchronous active-low reset
//     wb         : Wishbone slave modport (cyc/stb/we/addr/data/sel in,
//                  stall/ack/data/err out)
//
//   Optional feature, macro BKRAM_ERR_EN:
//     defined   - requests outside BKRAM_ADDR/BKRAM_MASK are accepted, leave
//                 memory untouched, and answer with o_wb_err in their slot.
//     undefined - every request is treated as a hit; o_wb_err is tied to 0.
// ---------------------------------------------------------------------------
module bkram_wb_responder
  import bus_pkg::*;
#(
  parameter int            AW         = BUS_AW,
  parameter int            DW         = BUS_DW,
  parameter int            LGMEMSZ    = 12,
  parameter logic [AW-1:0] BKRAM_ADDR = BKRAM_ADDR_DEF,
  parameter logic [AW-1:0] BKRAM_MASK = BKRAM_MASK_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  bkram_wb_responder_if.slave  wb
);

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic          accept;
  logic          win_hit;
  logic          req_err;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;

  // The responder never back-pressures, so every strobe inside a cycle is taken.
  assign accept  = wb.i_wb_cyc & wb.i_wb_stb;
  assign win_hit = ((wb.i_wb_addr ^ BKRAM_ADDR) & BKRAM_MASK) == '0;

`ifdef BKRAM_ERR_EN
  assign req_err = ~win_hit;
`else
  // Address decode belongs to the interconnect in this build.
  assign req_err = 1'b0;
  logic unused_hit;
  assign unused_hit = win_hit;
`endif

  // Errored requests must not disturb memory contents.
  assign ram_we = accept & wb.i_wb_we & ~req_err;
  assign ram_re = accept & ~wb.i_wb_we & ~req_err;

  // -------------------------------------------------------------------------
  // Stage 1 (cycle N): memory access, upper in-window bits alias
  // -------------------------------------------------------------------------
  bkram_bytewide #(
    .LGMEMSZ (LGMEMSZ),
    .DW      (DW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_re    (ram_re),
    .i_addr  (wb.i_wb_addr[LGMEMSZ-1:0]),
    .i_wdata (wb.i_wb_data),
    .i_sel   (wb.i_wb_sel),
    .o_rdata (ram_rdata)
  );

  // -------------------------------------------------------------------------
  // Response pipeline state
  // -------------------------------------------------------------------------
  rsp_e          rsp_p1_q, rsp_p1_d;
  logic          ack_p2_q, ack_p2_d;
  logic [DW-1:0] data_p2_q, data_p2_d;
  logic [1:0]    outst_q, outst_d;
  logic          rsp_out;

  // Slot type for the request accepted this cycle. Only stages that survive
  // a live cycle advance; i_wb_cyc low wipes every in-flight slot.
  always_comb begin
    rsp_p1_d = RSP_NONE;
    if (accept) begin
      rsp_p1_d = req_err ? RSP_ERR : RSP_ACK;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 (cycle N+1): capture read data into the output register
  // -------------------------------------------------------------------------
  always_comb begin
    ack_p2_d  = wb.i_wb_cyc & (rsp_p1_q == RSP_ACK);
    data_p2_d = data_p2_q;
    if (rsp_p1_q == RSP_ACK) begin
      data_p2_d = ram_rdata;
    end
  end

`ifdef BKRAM_ERR_EN
  logic err_p2_q, err_p2_d;

  assign err_p2_d = wb.i_wb_cyc & (rsp_p1_q == RSP_ERR);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_p2_q <= 1'b0;
    end else begin
      err_p2_q <= err_p2_d;
    end
  end

  assign wb.o_wb_err = err_p2_q;
`else
  assign wb.o_wb_err = 1'b0;
`endif

  assign rsp_out = ack_p2_q | wb.o_wb_err;

  // Outstanding-request count: +1 on accept, -1 per response, cleared by an
  // abort. With a fixed 2-cycle latency it saturates at 2.
  always_comb begin
    outst_d = outst_q;
    if (!wb.i_wb_cyc) begin
      outst_d = 2'd0;
    end else if (accept && !rsp_out) begin
      outst_d = outst_q + 2'd1;
    end else if (!accept && rsp_out) begin
      outst_d = outst_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rsp_p1_q  <= RSP_NONE;
      ack_p2_q  <= 1'b0;
      data_p2_q <= '0;
      outst_q   <= 2'd0;
    end else begin
      rsp_p1_q  <= rsp_p1_d;
      ack_p2_q  <= ack_p2_d;
      data_p2_q <= data_p2_d;
      outst_q   <= outst_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (outst_q != 2'd3);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (cycle N+2)
  // -------------------------------------------------------------------------
  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_ack   = ack_p2_q;
  assign wb.o_wb_data  = data_p2_q;

endmodule
